// File: rtl/uart_tx_block.sv
// uart_tx_block
//   Serial UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit,
//   each bit held for BIT_PERIOD clocks. Bytes are double-buffered through a
//   holding register in front of the shift register, so a sender can queue the
//   next byte while the current frame is on the line.
//
//   Optional build macro: UART_TX_STOP_CTRL_EN
//     defined   : adds input tx_stop_bit, captured with tx_data on every accept
//                 and driven as the stop-bit value of that frame
//     undefined : stop bit is always 1
//
// Ports
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   tx_data     byte to send, sampled only on an accept edge
//   tx_valid    sender has a byte on tx_data
//   tx_stop_bit (optional) stop-bit value for the byte on tx_data
//   tx_ready    holding register empty; accept = tx_valid & tx_ready at clk edge
//   serial_out  registered serial line, idles high
//   tx_busy     frame in progress
//   tx_done     one-cycle pulse at the edge that completes a stop bit
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (0) on the line
// DATA  | data bit shift_q[0] on the line, bit_idx counts 0..7
// STOP  | stop bit on the line; at its end reload from holding or go idle

module uart_tx_block #(
   parameter int BIT_PERIOD = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
`ifdef UART_TX_STOP_CTRL_EN
   input  logic       tx_stop_bit,
`endif
   output logic       tx_ready,
   output logic       serial_out,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CW = $clog2(BIT_PERIOD);
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic [2:0]      idx_q, idx_nxt;
   logic [7:0]      shift_q, hold_q;
   logic            hold_full_q, hold_full_nxt;
   logic            so_nxt, done_nxt;
   logic            accept, bit_end;
   logic            ld_shift_in, ld_shift_hold, ld_hold, shift_en;
   logic            frame_stop;

   assign accept   = tx_valid & ~hold_full_q;
   assign bit_end  = (cnt_q == CNT_LAST);
   assign tx_ready = ~hold_full_q;

   always_comb begin
      state_nxt     = state_q;
      cnt_nxt       = bit_end ? '0 : cnt_q + CW'(1);
      idx_nxt       = idx_q;
      hold_full_nxt = hold_full_q;
      so_nxt        = serial_out;
      done_nxt      = 1'b0;
      ld_shift_in   = 1'b0;
      ld_shift_hold = 1'b0;
      ld_hold       = 1'b0;
      shift_en      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_nxt = '0;
            so_nxt  = 1'b1;
            if (accept) begin
               ld_shift_in = 1'b1;
               state_nxt   = START;
               so_nxt      = 1'b0;
            end
         end
         START: begin
            ld_hold = accept;
            if (bit_end) begin
               state_nxt = DATA;
               idx_nxt   = '0;
               so_nxt    = shift_q[0];
            end
         end
         DATA: begin
            ld_hold = accept;
            if (bit_end) begin
               shift_en = 1'b1;
               if (idx_q == 3'd7) begin
                  state_nxt = STOP;
                  idx_nxt   = '0;
                  so_nxt    = frame_stop;
               end else begin
                  idx_nxt = idx_q + 3'd1;
                  so_nxt  = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               done_nxt = 1'b1;
               if (hold_full_q) begin
                  ld_shift_hold = 1'b1;
                  hold_full_nxt = 1'b0;
                  state_nxt     = START;
                  so_nxt        = 1'b0;
               end else if (accept) begin
                  // byte arriving exactly at frame end skips the holding register
                  ld_shift_in = 1'b1;
                  state_nxt   = START;
                  so_nxt      = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  so_nxt    = 1'b1;
               end
            end else begin
               ld_hold = accept;
            end
         end
         default: begin
            state_nxt = IDLE;
            so_nxt    = 1'b1;
         end
      endcase

      if (ld_hold) hold_full_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         hold_full_q <= 1'b0;
         serial_out  <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cnt_q       <= cnt_nxt;
         idx_q       <= idx_nxt;
         hold_full_q <= hold_full_nxt;
         serial_out  <= so_nxt;
         tx_busy     <= (state_nxt != IDLE);
         tx_done     <= done_nxt;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shift_q <= '0;
         hold_q  <= '0;
      end else begin
         if (ld_shift_in)        shift_q <= tx_data;
         else if (ld_shift_hold) shift_q <= hold_q;
         else if (shift_en)      shift_q <= {1'b0, shift_q[7:1]};
         if (ld_hold) hold_q <= tx_data;
      end
   end

`ifdef UART_TX_STOP_CTRL_EN
   logic stop_q, hold_stop_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stop_q      <= 1'b1;
         hold_stop_q <= 1'b1;
      end else begin
         if (ld_shift_in)        stop_q <= tx_stop_bit;
         else if (ld_shift_hold) stop_q <= hold_stop_q;
         if (ld_hold) hold_stop_q <= tx_stop_bit;
      end
   end

   assign frame_stop = stop_q;
`else
   assign frame_stop = 1'b1;
`endif

endmodule

// File: tb/tb_uart_tx_block.sv
module tb_uart_tx_block;

   localparam int P = 10;

   logic       tb_clk;
   logic       n_rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_stop_bit;
   logic       tx_ready, serial_out, tx_busy, tx_done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int rst_epoch = 0;

   uart_tx_block #(.BIT_PERIOD(P)) dut (
      .clk        (tb_clk),
      .n_rst      (n_rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
`ifdef UART_TX_STOP_CTRL_EN
      .tx_stop_bit(tx_stop_bit),
`endif
      .tx_ready   (tx_ready),
      .serial_out (serial_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   initial forever begin
      @(posedge tb_clk);
      cyc++;
   end

   initial forever begin
      @(negedge n_rst);
      rst_epoch++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The line is a queue of future per-clock values; a frame is appended as
   // 10*P samples when it may start. At most one byte waits behind it.
   logic q_line[$];
   logic [7:0] started_q[$];
   logic       held_v, active;
   logic [7:0] held_b;
   logic       held_s;
   logic       e_so, e_ready, e_busy, e_done;

   task automatic push_frame(input logic [7:0] b, input logic s);
      logic [9:0] fr;
      fr = {s, b, 1'b0};
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < P; j++) q_line.push_back(fr[i]);
      started_q.push_back(b);
   endtask

   initial begin
      logic acc, s_in;
      held_v = 0; active = 0; held_b = 0; held_s = 1;
      e_so = 1; e_ready = 1; e_busy = 0; e_done = 0;
      forever begin
         @(posedge tb_clk or negedge n_rst);
         if (!n_rst) begin
            q_line.delete();
            held_v = 0; active = 0;
            e_so = 1; e_ready = 1; e_busy = 0; e_done = 0;
         end else begin
`ifdef UART_TX_STOP_CTRL_EN
            s_in = tx_stop_bit;
`else
            s_in = 1'b1;
`endif
            acc    = tx_valid && !held_v;
            e_done = 0;
            if (q_line.size() == 0 && active) begin
               e_done = 1;
               active = 0;
            end
            if (q_line.size() == 0 && held_v) begin
               push_frame(held_b, held_s);
               held_v = 0;
            end else if (q_line.size() == 0 && acc) begin
               push_frame(tx_data, s_in);
               acc = 0;
            end
            if (acc) begin
               held_v = 1; held_b = tx_data; held_s = s_in;
            end
            if (q_line.size() != 0) begin
               e_so = q_line.pop_front();
               active = 1;
            end else begin
               e_so = 1;
            end
            e_busy  = active;
            e_ready = !held_v;
         end
      end
   end

   initial forever begin
      @(negedge tb_clk);
      if (n_rst === 1'b1) begin
         chk("serial_out", serial_out, e_so);
         chk("tx_ready",   tx_ready,   e_ready);
         chk("tx_busy",    tx_busy,    e_busy);
         chk("tx_done",    tx_done,    e_done);
      end
   end

   // ---------------- passive line receiver ----------------
   logic [7:0] rx_bytes[$];
   logic       rx_stops[$];

   initial forever begin
      int ep;
      logic st, sp;
      logic [7:0] b;
      @(negedge serial_out);
      ep = rst_epoch;
      if (n_rst !== 1'b1) continue;
      repeat (P/2) @(negedge tb_clk);
      st = serial_out;
      for (int i = 0; i < 8; i++) begin
         repeat (P) @(negedge tb_clk);
         b[i] = serial_out;
      end
      repeat (P) @(negedge tb_clk);
      sp = serial_out;
      if (ep == rst_epoch && n_rst === 1'b1 && st == 1'b0) begin
         rx_bytes.push_back(b);
         rx_stops.push_back(sp);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] b, input logic s, output int waits);
      logic rdy;
      waits = 0;
      @(negedge tb_clk);
      tx_data = b; tx_stop_bit = s; tx_valid = 1'b1;
      while (1) begin
         rdy = tx_ready;
         @(posedge tb_clk);
         if (rdy) break;
         waits++;
         if (waits > 500) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte %0h not accepted, expected within 500 cycles", b);
            break;
         end
         @(negedge tb_clk);
      end
      #1 tx_valid = 1'b0;
      tx_stop_bit = 1'b1;
   endtask

   task automatic wait_done(input string name, output int t);
      int k;
      t = -1;
      for (k = 0; k < 400; k++) begin
         @(negedge tb_clk);
         if (tx_done) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no tx_done within 400 cycles, expected a pulse", name);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge tb_clk);
         k++;
      end while (tx_busy && k < 1000);
      chk("idle_reached", tx_busy, 0);
      repeat (120) @(negedge tb_clk);
   endtask

   // single-frame check against the hand-computed line pattern
   task automatic frame_literal(input string name, input logic [9:0] pat, output int done_k);
      done_k = -1;
      for (int k = 0; k < 150; k++) begin
         @(negedge tb_clk);
         if (k % P == P/2 && k / P < 10) chk(name, serial_out, pat[k / P]);
         if (tx_done) begin
            done_k = k;
            break;
         end
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int w, t1, t2, dk;
      logic seen;
      logic [7:0] exp_rx[$];
      logic       exp_sp[$];
      logic [7:0] exp_st[$];

      n_rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_stop_bit = 1'b1;
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk) n_rst = 1'b1;
      @(negedge tb_clk);
      chk("rst_serial_out", serial_out, 1);
      chk("rst_tx_ready",   tx_ready,   1);
      chk("rst_tx_busy",    tx_busy,    0);
      chk("rst_tx_done",    tx_done,    0);

      // reset in the middle of DATA with a byte waiting in holding
      send(8'hD5, 1'b1, w);
      send(8'h3C, 1'b1, w);
      repeat (30) @(posedge tb_clk);
      #3 n_rst = 1'b0;
      #1;
      chk("abort_serial_out", serial_out, 1);
      chk("abort_tx_ready",   tx_ready,   1);
      chk("abort_tx_busy",    tx_busy,    0);
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk) n_rst = 1'b1;
      seen = 0;
      repeat (150) begin
         @(negedge tb_clk);
         if (tx_done) seen = 1;
      end
      chk("abort_no_done", seen, 0);

      // single byte 0xD5: line 0,1,0,1,0,1,0,1,1,1
      send(8'hD5, 1'b1, w);
      chk("single_accept_wait", w, 0);
      frame_literal("single_bit", 10'b1110101010, dk);
      chk("single_done_clock", dk, 100);
      chk("single_busy_fall", tx_busy, 0);
      wait_idle();

      // back-to-back: second byte during the start bit
      send(8'hD5, 1'b1, w);
      repeat (3) @(posedge tb_clk);
      send(8'h3C, 1'b1, w);
      @(negedge tb_clk);
      chk("b2b_ready_low", tx_ready, 0);
      wait_done("b2b_done1", t1);
      chk("b2b_ready_back", tx_ready, 1);
      chk("b2b_no_gap", serial_out, 0);
      wait_done("b2b_done2", t2);
      chk("b2b_done_spacing", t2 - t1, 100);
      chk("b2b_busy_fall", tx_busy, 0);
      wait_idle();

      // backpressure: third byte waits while holding is full
      send(8'hD5, 1'b1, w);
      send(8'h3C, 1'b1, w);
      send(8'hA7, 1'b1, w);
      chk("bp_wait_cycles", w, 99);
      wait_idle();

      // loopback bytes
      send(8'h55, 1'b1, w);
      send(8'hFF, 1'b1, w);
      wait_idle();

`ifdef UART_TX_STOP_CTRL_EN
      send(8'hD5, 1'b0, w);
      frame_literal("stopctl_bit", 10'b0110101010, dk);
      chk("stopctl_done_clock", dk, 100);
      chk("stopctl_idle_high", serial_out, 1);
      wait_idle();
`endif

      exp_st = '{8'hD5, 8'hD5, 8'hD5, 8'h3C, 8'hD5, 8'h3C, 8'hA7, 8'h55, 8'hFF};
      exp_rx = '{8'hD5, 8'hD5, 8'h3C, 8'hD5, 8'h3C, 8'hA7, 8'h55, 8'hFF};
      exp_sp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef UART_TX_STOP_CTRL_EN
      exp_st.push_back(8'hD5);
      exp_rx.push_back(8'hD5);
      exp_sp.push_back(1'b0);
`endif
      chk("model_frame_count", started_q.size(), exp_st.size());
      for (int i = 0; i < exp_st.size() && i < started_q.size(); i++)
         chk("model_frame_order", started_q[i], exp_st[i]);
      chk("rx_count", rx_bytes.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size() && i < rx_bytes.size(); i++) begin
         chk("rx_byte", rx_bytes[i], exp_rx[i]);
         chk("rx_stop", rx_stops[i], exp_sp[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
